rasterization2_wrapper: RTL
===========================

Name: rasterization2_wrapper

Overview:
- LII wrapper for the rasterization2 HLS kernel, directly downstream of the rasterization1 stage.
- Input side: unpacks each 128-bit LII beat (triangle_2d_copy in [113:58], triangle_info in [57:0]) into two independently buffered kernel streams.
- Output side: packs the kernel's 32-bit fragment stream PACK-per-beat into LII output words, with an idle-timeout flush for partial beats.
- Drives the kernel clock enable.

Parameters:
- PW, 128, packing width; must be >= 114 and >= PACK*32+4.
- DEPTH, 4, entries per input FIFO (power of 2, >= 2).
- PACK, 3, fragments per output beat (1..3 at PW=128).
- FLUSH_CYCLES, 16, idle cycles before a partial beat is emitted (>= 1).
- SRC_ID, 8'h00, constant driven on lii_out_p0_src.
- DST_ID, 8'h00, constant driven on lii_out_p0_dst.

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- lii_in_p0_tdata  in  PW  packed input beat
- lii_in_p0_tvalid  in  1  input valid
- lii_in_p0_tready  out  1  input ready
- lii_in_p0_src  in  8  ignored
- lii_in_p0_dst  in  8  ignored
- lii_out_p0_tdata  out  PW  packed output beat
- lii_out_p0_tvalid  out  1  output valid
- lii_out_p0_tready  in  1  output ready
- lii_out_p0_src  out  8  SRC_ID
- lii_out_p0_dst  out  8  DST_ID
- triangle_2d_copy_stream_tdata  out  56  to kernel
- triangle_2d_copy_stream_tvalid  out  1
- triangle_2d_copy_stream_tready  in  1
- triangle_info_stream_tdata  out  58  to kernel
- triangle_info_stream_tvalid  out  1
- triangle_info_stream_tready  in  1
- fragment_stream_tdata  in  32  from kernel {color,z,y,x}
- fragment_stream_tvalid  in  1
- fragment_stream_tready  out  1
- ce  out  1  kernel clock enable

Behaviour:
- Interface: one clock, aclk. arstn is asynchronous and active-low.
- Reset (arstn low):
  - Both FIFOs empty; accumulator, lane count and idle counter are 0; output register invalid.
  - While arstn is low: lii_in_p0_tready=0, all tvalid outputs=0, fragment_stream_tready=0, ce=0.
  - Reset mid-operation discards all buffered data; no partial beat is emitted.
- Input unpack:
  - lii_in_p0_tready = arstn & !full_tri & !full_info.
  - On accept (tvalid & tready), push [113:58] into the tri FIFO and [57:0] into the info FIFO in the same cycle.
  - Both FIFOs are first-word-fall-through: kernel tvalid = !empty, tdata = head entry, pop on tvalid & tready.
  - The two streams drain independently. Push and pop in the same cycle are legal at any occupancy; a full FIFO blocks push only.
- Output pack:
  - One accumulator (PACK lanes) plus one output register.
  - stall = out_valid & !lii_out_p0_tready.
  - fragment_stream_tready = arstn & !stall.
  - An accepted fragment goes into lane cnt at bits [32*cnt+31:32*cnt]; cnt then increments. Lane 0 is the oldest fragment.
- Beat emit:
  - Trigger: a fragment is accepted with cnt==PACK-1 (a full beat, holding the new fragment), or a flush fires.
  - On trigger, accumulator contents move to the output register and out_valid is set.
  - Bits [99:96] = number of valid lanes (1..PACK). Unused lanes and bits [PW-1:100] are zero.
  - cnt and the accumulator clear in the same cycle. The beat is visible on the LII output the cycle after the trigger.
- Flush:
  - idle counts cycles with cnt>0, no fragment accepted, and !stall. It resets to 0 on any accept or when cnt==0.
  - The flush fires when idle == FLUSH_CYCLES-1 and a cycle qualifies.
  - No flush while stalled; the counter holds during a stall.
- Output register:
  - Cleared when lii_out_p0_tready is high and no new beat loads.
  - Back-to-back load and drain in one cycle sustains 1 beat/cycle.
- Clock enable: ce = arstn & !stall.
- tdata on any stream is don't-care when its tvalid is 0, except lii_out_p0_tdata, which holds its last value.

Decomposition:
- Package rast_pkg holds:
  - widths TRI2D_W=56, INFO_W=58, FRAG_W=32;
  - field offsets TRI2D_LSB=58, CNT_LSB=96, CNT_W=4.
- One sub-module, lii_fwft_fifo (parameters WIDTH, DEPTH; count-based full/empty), instantiated twice.
- Packer and flush logic stay in the wrapper.

Test Plan:
- Single input beat {56'hA5_0000_0000_0001, 58'h1234} with both kernel readys high: tri tdata = 56'hA5_0000_0000_0001 and info tdata = 58'h1234, both valid one cycle after accept.
- triangle_info_stream_tready held 0, DEPTH=4, 6 beats offered: exactly 4 accepted, then lii_in_p0_tready=0. Releasing info ready drains info in order; the tri FIFO behaves independently.
- 3 fragments 32'h11,22,33 back-to-back, output ready high: one beat with [31:0]=11, [63:32]=22, [95:64]=33, [99:96]=3, one cycle after the third accept.
- 2 fragments, then idle with FLUSH_CYCLES=16: partial beat with count=2 and lane 2 zero, emitted FLUSH_CYCLES cycles after the last accept; no flush if a third fragment arrives at idle=15.
- lii_out_p0_tready=0 while a beat is pending: ce=0, fragment_stream_tready=0, flush counter frozen, tdata stable. Releasing ready drains the beat and ce returns to 1.
- arstn pulsed low with cnt=2 and both FIFOs partially full: all valids 0 immediately; after release, no stale beat or FIFO entry appears.

Source files
------------

// File: rtl/rast_pkg.sv
// Shared widths and field offsets for the rasterization2 LII wrapper.
package rast_pkg;

  localparam int TRI2D_W   = 56;
  localparam int INFO_W    = 58;
  localparam int FRAG_W    = 32;
  localparam int TRI2D_LSB = 58;
  localparam int CNT_LSB   = 96;
  localparam int CNT_W     = 4;

  typedef logic [FRAG_W-1:0] frag_t;

endpackage

// File: rtl/lii_fwft_fifo.sv
// First-word-fall-through FIFO; head entry is always visible on dout while not empty.
module lii_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array: contents are qualified by count_r, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rasterization2_wrapper.sv
// LII wrapper for rasterization2: splits input beats into two kernel streams and
// packs the kernel's fragment stream into LII beats with an idle-timeout flush.
module rasterization2_wrapper
  import rast_pkg::*;
#(
  parameter int         PW           = 128,
  parameter int         DEPTH        = 4,
  parameter int         PACK         = 3,
  parameter int         FLUSH_CYCLES = 16,
  parameter logic [7:0] SRC_ID       = 8'h00,
  parameter logic [7:0] DST_ID       = 8'h00
) (
  input  logic               aclk,
  input  logic               arstn,
  input  logic [PW-1:0]      lii_in_p0_tdata,
  input  logic               lii_in_p0_tvalid,
  output logic               lii_in_p0_tready,
  input  logic [7:0]         lii_in_p0_src,
  input  logic [7:0]         lii_in_p0_dst,
  output logic [PW-1:0]      lii_out_p0_tdata,
  output logic               lii_out_p0_tvalid,
  input  logic               lii_out_p0_tready,
  output logic [7:0]         lii_out_p0_src,
  output logic [7:0]         lii_out_p0_dst,
  output logic [TRI2D_W-1:0] triangle_2d_copy_stream_tdata,
  output logic               triangle_2d_copy_stream_tvalid,
  input  logic               triangle_2d_copy_stream_tready,
  output logic [INFO_W-1:0]  triangle_info_stream_tdata,
  output logic               triangle_info_stream_tvalid,
  input  logic               triangle_info_stream_tready,
  input  frag_t              fragment_stream_tdata,
  input  logic               fragment_stream_tvalid,
  output logic               fragment_stream_tready,
  output logic               ce
);

  localparam int ACC_W  = PACK * FRAG_W;
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(PACK - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(PACK);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);

  logic full_tri_s, full_info_s, empty_tri_s, empty_info_s, push_s;

  assign lii_in_p0_tready = arstn & ~full_tri_s & ~full_info_s;
  assign push_s           = lii_in_p0_tvalid & lii_in_p0_tready;

  lii_fwft_fifo #(.WIDTH(TRI2D_W), .DEPTH(DEPTH)) u_tri_fifo (
    .clk   (aclk),
    .rst_n (arstn),
    .push  (push_s),
    .din   (lii_in_p0_tdata[TRI2D_LSB +: TRI2D_W]),
    .full  (full_tri_s),
    .pop   (triangle_2d_copy_stream_tvalid & triangle_2d_copy_stream_tready),
    .dout  (triangle_2d_copy_stream_tdata),
    .empty (empty_tri_s)
  );

  lii_fwft_fifo #(.WIDTH(INFO_W), .DEPTH(DEPTH)) u_info_fifo (
    .clk   (aclk),
    .rst_n (arstn),
    .push  (push_s),
    .din   (lii_in_p0_tdata[INFO_W-1:0]),
    .full  (full_info_s),
    .pop   (triangle_info_stream_tvalid & triangle_info_stream_tready),
    .dout  (triangle_info_stream_tdata),
    .empty (empty_info_s)
  );

  assign triangle_2d_copy_stream_tvalid = ~empty_tri_s;
  assign triangle_info_stream_tvalid    = ~empty_info_s;

  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDLE_W-1:0] idle_r;
  logic              out_valid_r;
  logic [PW-1:0]     out_data_r;
  logic              stall_s, accept_s, full_trig_s, flush_s, emit_s;
  logic [ACC_W-1:0]  acc_ins_s;
  logic [PW-1:0]     beat_s;

  assign stall_s                = out_valid_r & ~lii_out_p0_tready;
  assign fragment_stream_tready = arstn & ~stall_s;
  assign ce                     = arstn & ~stall_s;
  assign accept_s               = fragment_stream_tvalid & fragment_stream_tready;
  assign full_trig_s            = accept_s & (cnt_r == LAST_LANE);
  // Partial-beat timeout; a stall freezes it and any accept pre-empts it.
  assign flush_s = (cnt_r != {CNT_W{1'b0}}) & ~accept_s & ~stall_s & (idle_r == IDLE_LAST);
  assign emit_s  = full_trig_s | flush_s;

  // Accumulator view with the incoming fragment dropped into lane cnt_r.
  always_comb begin
    acc_ins_s = acc_r;
    for (int l = 0; l < PACK; l++) begin
      if (accept_s && (cnt_r == CNT_W'(l))) begin
        acc_ins_s[l*FRAG_W +: FRAG_W] = fragment_stream_tdata;
      end else begin
        acc_ins_s[l*FRAG_W +: FRAG_W] = acc_r[l*FRAG_W +: FRAG_W];
      end
    end
  end

  // Outgoing beat: lanes low, lane count at CNT_LSB, everything else zero.
  always_comb begin
    beat_s                     = {PW{1'b0}};
    beat_s[ACC_W-1:0]          = acc_ins_s;
    beat_s[CNT_LSB +: CNT_W]   = full_trig_s ? FULL_CNT : cnt_r;
  end

  // Lane accumulator, lane count and idle counter.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      acc_r  <= {ACC_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      idle_r <= {IDLE_W{1'b0}};
    end else if (emit_s) begin
      acc_r  <= {ACC_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      idle_r <= {IDLE_W{1'b0}};
    end else if (accept_s) begin
      acc_r  <= acc_ins_s;
      cnt_r  <= cnt_r + CNT_W'(1'b1);
      idle_r <= {IDLE_W{1'b0}};
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (!stall_s) begin
      idle_r <= idle_r + IDLE_W'(1'b1);
    end else begin
      idle_r <= idle_r;
    end
  end

  // Output register; data is kept after drain so tdata holds its last value.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {PW{1'b0}};
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= beat_s;
    end else if (lii_out_p0_tready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign lii_out_p0_tdata  = out_data_r;
  assign lii_out_p0_tvalid = out_valid_r;
  assign lii_out_p0_src    = SRC_ID;
  assign lii_out_p0_dst    = DST_ID;

  logic unused_s;
  assign unused_s = ^{lii_in_p0_src, lii_in_p0_dst, lii_in_p0_tdata};

endmodule
